ft_recovery_ctrl: RTL and testbench

FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

---
 rtl/ft_pkg.sv | 15 +
 rtl/ft_recovery_ctrl.sv | 123 ++++++++++++
 tb/tb_ft_recovery_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// Shared types and default widths for the fault-tolerant recovery controller.
package ft_pkg;

  localparam int FT_ADDR_WIDTH = 5;
  localparam int FT_DATA_WIDTH = 2 ** FT_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } ft_state_e;

endpackage

// File: rtl/ft_recovery_ctrl.sv
// Recovery sequencer: halts both cores, then copies every checkpoint word
// into the register files and pulses done.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no recovery; waiting for a rising edge on fetch_block_i
// ST_HALT  | cores stalled, one drain cycle before reading
// ST_READ  | sweeping raddr_o 0..last, writing the previous word
// ST_DRAIN | final register-file write of the last address
// ST_DONE  | done pulse; back to IDLE, or straight to HALT if pending
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_block_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  done_o,
  output logic [7:0]            recovery_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ft_state_e             state_q;
  logic                  fetch_prev_q;
  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  halt_q;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  done_q;
  logic [7:0]            recovery_cnt_q;
  logic                  start;

  assign start = fetch_block_i & ~fetch_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      fetch_prev_q   <= 1'b0;
      pending_q      <= 1'b0;
      raddr_q        <= '0;
      halt_q         <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      done_q         <= 1'b0;
      recovery_cnt_q <= '0;
    end else begin
      fetch_prev_q <= fetch_block_i;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          halt_q  <= 1'b0;
          raddr_q <= '0;
          if (start) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (start) pending_q <= 1'b1;
          state_q <= ST_READ;
          raddr_q <= '0;
        end
        ST_READ: begin
          if (start) pending_q <= 1'b1;
          // rdata_i belongs to the address presented this cycle
          rf_we_q    <= 1'b1;
          rf_waddr_q <= raddr_q;
          rf_wdata_q <= rdata_i;
          if (raddr_q == LAST_ADDR) begin
            state_q <= ST_DRAIN;
            raddr_q <= '0;
          end else begin
            raddr_q <= raddr_q + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (start) pending_q <= 1'b1;
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          if (recovery_cnt_q != 8'hFF) recovery_cnt_q <= recovery_cnt_q + 8'd1;
        end
        ST_DONE: begin
          if (pending_q || start) begin
            pending_q <= 1'b0;
            state_q   <= ST_HALT;
          end else begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          halt_q  <= 1'b0;
          raddr_q <= '0;
        end
      endcase
    end
  end

  assign raddr_o        = raddr_q;
  assign halt_o         = halt_q;
  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign done_o         = done_q;
  assign recovery_cnt_o = recovery_cnt_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl against a relative-time model of
// a recovery (cycle k after the start edge determines every output).
module tb_ft_recovery_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          fetch_block_i = 1'b0;
  logic [DW-1:0] rdata_i;
  logic [AW-1:0] raddr_o;
  logic          halt_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          done_o;
  logic [7:0]    recovery_cnt_o;

  logic [DW-1:0] mem [NW];
  int errors = 0;
  int checks = 0;

  // model: active recovery, cycle index k (1 = first cycle after start edge)
  bit m_active, m_pend, m_prev;
  int m_k;
  int m_cnt;

  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_block_i(fetch_block_i), .rdata_i(rdata_i),
    .raddr_o(raddr_o), .halt_o(halt_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .done_o(done_o), .recovery_cnt_o(recovery_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign rdata_i = mem[raddr_o];

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_prev = 0; m_k = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit start;
    start  = fetch_block_i && !m_prev;
    m_prev = fetch_block_i;
    if (!m_active) begin
      if (start) begin m_active = 1; m_k = 1; end
    end else begin
      if (start) m_pend = 1;
      m_k++;
      if (m_k == 36) begin
        if (m_pend) begin m_k = 1; m_pend = 0; end
        else begin m_active = 0; m_k = 0; end
      end
    end
    if (m_active && m_k == 35 && m_cnt != 255) m_cnt++;
  endtask

  function automatic bit exp_we();
    return m_active && m_k >= 3 && m_k <= 34;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [AW-1:0] ra;
    ra = (m_active && m_k >= 2 && m_k <= 33) ? AW'(m_k - 2) : '0;
    return {m_active, exp_we(), (m_active && m_k == 35), ra, 8'(m_cnt)};
  endfunction

  function automatic logic [AW+DW-1:0] exp_wr();
    return {AW'(m_k - 3), mem[m_k - 3]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    fetch_block_i = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o, rf_waddr_o, rf_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o, rf_waddr_o, rf_wdata_o});
    end
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int writes = 0;
    int done_at = -1;
    for (int i = 0; i < NW; i++) mem[i] = 32'(i * 10);
    do_reset();
    fetch_block_i = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (c == 1) fetch_block_i = 1'b0;
      if (rf_we_o) writes++;
      if (done_o) done_at = c + 1;
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL single c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
      if (exp_we()) begin
        checks++;
        if ({rf_waddr_o, rf_wdata_o} !== exp_wr()) begin
          errors++;
          $display("FAIL single_wr c=%0d got=%h exp=%h", c, {rf_waddr_o, rf_wdata_o}, exp_wr());
        end
      end
    end
    checks++;
    if (writes != 32 || done_at != 35 || recovery_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL single_summary writes=%0d done_at=T+%0d cnt=%0d exp 32/T+35/1",
               writes, done_at, recovery_cnt_o);
    end
  endtask

  task automatic test_held_high();
    int dones = 0;
    do_reset();
    fetch_block_i = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (c == 99) fetch_block_i = 1'b0;
      if (done_o) dones++;
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL held c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
    end
    checks++;
    if (dones != 1 || recovery_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL held_summary dones=%0d cnt=%0d exp 1/1", dones, recovery_cnt_o);
    end
  endtask

  task automatic test_second_edge();
    int writes = 0;
    int halt_gaps = 0;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    do_reset();
    fetch_block_i = 1'b1;
    for (int c = 0; c < 85; c++) begin
      tick();
      fetch_block_i = (c == 9);
      if (rf_we_o) writes++;
      if (c < 70 && !halt_o) halt_gaps++;
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL second c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
      if (exp_we()) begin
        checks++;
        if ({rf_waddr_o, rf_wdata_o} !== exp_wr()) begin
          errors++;
          $display("FAIL second_wr c=%0d got=%h exp=%h", c, {rf_waddr_o, rf_wdata_o}, exp_wr());
        end
      end
    end
    checks++;
    if (writes != 64 || halt_gaps != 0 || recovery_cnt_o !== 8'd2) begin
      errors++;
      $display("FAIL second_summary writes=%0d halt_gaps=%0d cnt=%0d exp 64/0/2",
               writes, halt_gaps, recovery_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    do_reset();
    fetch_block_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      fetch_block_i = 1'b0;
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o, rf_waddr_o, rf_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0",
               {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o, rf_waddr_o, rf_wdata_o});
    end
    model_reset();
    repeat (2) tick();
    rst_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rf_we_o) writes++;
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("FAIL reset_mid_writes got=%0d exp=0", writes);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) fetch_block_i = ~fetch_block_i;
      tick();
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
      if (exp_we()) begin
        checks++;
        if ({rf_waddr_o, rf_wdata_o} !== exp_wr()) begin
          errors++;
          $display("FAIL random_wr c=%0d got=%h exp=%h", c, {rf_waddr_o, rf_wdata_o}, exp_wr());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 260 * 35 + 80; c++) begin
      fetch_block_i = (c < 260 * 35) && ((c % 8) < 4);
      tick();
      checks++;
      if ({halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c,
                 {halt_o, rf_we_o, done_o, raddr_o, recovery_cnt_o}, exp_vec());
      end
    end
    checks++;
    if (recovery_cnt_o !== 8'd255 || halt_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_saturate cnt=%0d halt=%0b exp 255/0", recovery_cnt_o, halt_o);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NW; i++) mem[i] = '0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_held_high();
    test_second_edge();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
